// File: rtl/qbert_color_tracker_if.sv
// Cube-colour interface between the Q*bert layer / map renderer and the
// colour tracker.
//   master : renderer side; drives start/pause/landing/position, reads colours
//   slave  : tracker side; reads the requests, drives colours and status
interface qbert_color_tracker_if #(
  parameter int N_CUBE = 28
) ();
  logic              e_start_qb;
  logic              e_pause_qb;
  logic              done_move;
  logic [N_CUBE-1:0] position_qb;
  logic [N_CUBE-1:0] e_color_state;
  logic [4:0]        cubes_done;
  logic              level_done;
  logic              flash;
  logic [1:0]        tracker_state;
  logic              err_pos;

  modport master (
    output e_start_qb, e_pause_qb, done_move, position_qb,
    input  e_color_state, cubes_done, level_done, flash, tracker_state, err_pos
  );

  modport slave (
    input  e_start_qb, e_pause_qb, done_move, position_qb,
    output e_color_state, cubes_done, level_done, flash, tracker_state, err_pos
  );
endinterface

// File: rtl/qbert_color_tracker.sv
// Q*bert cube colour tracker.
// Records which pyramid top faces have been coloured by landings, counts them,
// detects level completion, runs a blink sequence, then holds all-lit.
//   CLK_33 : 33 MHz pixel clock
//   reset  : asynchronous, active-low
//   bus    : qbert_color_tracker_if.slave (start/pause/landing/position in,
//            colour vector, count, level_done, flash, state, err_pos out)

// One cube's top-face colour bit.
module qbert_cube_cell #(
  parameter bit TOGGLE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hit,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (hit) q <= TOGGLE ? ~q : 1'b1;
  end
endmodule

module qbert_color_tracker #(
  parameter int N_CUBE        = 28,
  parameter int TOGGLE_MODE   = 0,
  parameter int FLASH_HALF    = 33000000/8,
  parameter int FLASH_TOGGLES = 8
) (
  input  logic                  CLK_33,
  input  logic                  reset,
  qbert_color_tracker_if.slave  bus
);
  localparam int FCW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int TCW = $clog2(FLASH_TOGGLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_FLASH = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic              done_d;
  logic [N_CUBE-1:0] color_q, hit;
  logic [4:0]        cnt_q, cnt_nxt;
  logic [FCW-1:0]    fcnt_q, fcnt_nxt;
  logic [TCW-1:0]    tcnt_q, tcnt_nxt;
  logic              flash_q, flash_nxt;
  logic              lvl_q, lvl_nxt;
  logic              err_q, err_nxt;

  logic              start, landing, pos_nz, pos_one, accept, was_set, inc, dec;
  logic [N_CUBE-1:0] pos;

  assign start   = bus.e_start_qb;
  assign pos     = bus.position_qb;
  assign landing = bus.done_move & ~done_d;
  assign pos_nz  = |pos;
  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign pos_one = pos_nz && ((pos & (pos - {{(N_CUBE-1){1'b0}}, 1'b1})) == '0);
  // Start takes priority, so a coincident landing never reaches the cells.
  assign accept  = (state == S_PLAY) && landing && !bus.e_pause_qb && !start && pos_one;
  assign hit     = accept ? pos : '0;
  assign was_set = |(pos & color_q);
  assign inc     = accept & ~was_set;
  assign dec     = (TOGGLE_MODE != 0) & accept & was_set;

  for (genvar i = 0; i < N_CUBE; i++) begin : g_cube
    qbert_cube_cell #(.TOGGLE(TOGGLE_MODE != 0)) u_cell (
      .clk   (CLK_33),
      .rst_n (reset),
      .clr   (start),
      .hit   (hit[i]),
      .q     (color_q[i])
    );
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      done_d  <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      flash_q <= 1'b0;
      lvl_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_d  <= bus.done_move;
      cnt_q   <= cnt_nxt;
      fcnt_q  <= fcnt_nxt;
      tcnt_q  <= tcnt_nxt;
      flash_q <= flash_nxt;
      lvl_q   <= lvl_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    fcnt_nxt  = fcnt_q;
    tcnt_nxt  = tcnt_q;
    flash_nxt = flash_q;
    lvl_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (start) begin
      state_nxt = S_PLAY;
      cnt_nxt   = '0;
      fcnt_nxt  = '0;
      tcnt_nxt  = '0;
      flash_nxt = 1'b0;
    end else begin
      case (state)
        S_PLAY: begin
          // Multi-bit position is a renderer fault; all-zero is a fall-off.
          if (landing && !bus.e_pause_qb && pos_nz && !pos_one) err_nxt = 1'b1;
          if (inc) begin
            cnt_nxt = cnt_q + 5'd1;
            if (cnt_q == 5'(N_CUBE - 1)) begin
              lvl_nxt   = 1'b1;
              state_nxt = S_FLASH;
              fcnt_nxt  = '0;
              tcnt_nxt  = '0;
              flash_nxt = 1'b1;
            end
          end else if (dec) begin
            cnt_nxt = cnt_q - 5'd1;
          end
        end
        S_FLASH: begin
          if (!bus.e_pause_qb) begin
            if (fcnt_q == FCW'(FLASH_HALF - 1)) begin
              fcnt_nxt  = '0;
              flash_nxt = ~flash_q;
              tcnt_nxt  = tcnt_q + 1'b1;
              if (tcnt_q == TCW'(FLASH_TOGGLES - 1)) begin
                state_nxt = S_DONE;
                flash_nxt = 1'b0;
              end
            end else begin
              fcnt_nxt = fcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_PLAY:  bus.e_color_state = color_q;
      S_FLASH: bus.e_color_state = {N_CUBE{flash_q}};
      S_DONE:  bus.e_color_state = '1;
      default: bus.e_color_state = '0;
    endcase
  end

  assign bus.cubes_done    = cnt_q;
  assign bus.level_done    = lvl_q;
  assign bus.flash         = flash_q;
  assign bus.tracker_state = state;
  assign bus.err_pos       = err_q;
endmodule

// File: tb/tb_qbert_color_tracker.sv
module tb_qbert_color_tracker;
  localparam int N = 28;
  localparam logic [N-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, dm = 1'b0;
  logic [N-1:0] pos = '0;
  always #5 clk = ~clk;

  qbert_color_tracker_if #(.N_CUBE(N)) b0 ();
  qbert_color_tracker_if #(.N_CUBE(N)) b1 ();
  assign b0.e_start_qb = start;  assign b1.e_start_qb = start;
  assign b0.e_pause_qb = pause;  assign b1.e_pause_qb = pause;
  assign b0.done_move  = dm;     assign b1.done_move  = dm;
  assign b0.position_qb = pos;   assign b1.position_qb = pos;

  qbert_color_tracker #(.N_CUBE(N), .TOGGLE_MODE(0), .FLASH_HALF(4), .FLASH_TOGGLES(8))
    dut0 (.CLK_33(clk), .reset(rst_n), .bus(b0.slave));
  qbert_color_tracker #(.N_CUBE(N), .TOGGLE_MODE(1), .FLASH_HALF(4), .FLASH_TOGGLES(8))
    dut1 (.CLK_33(clk), .reset(rst_n), .bus(b1.slave));

  logic [N-1:0] a_col [2];
  logic [4:0]   a_cnt [2];
  logic         a_ld [2], a_fl [2], a_err [2];
  logic [1:0]   a_st [2];
  assign a_col[0] = b0.e_color_state; assign a_col[1] = b1.e_color_state;
  assign a_cnt[0] = b0.cubes_done;    assign a_cnt[1] = b1.cubes_done;
  assign a_ld[0]  = b0.level_done;    assign a_ld[1]  = b1.level_done;
  assign a_fl[0]  = b0.flash;         assign a_fl[1]  = b1.flash;
  assign a_err[0] = b0.err_pos;       assign a_err[1] = b1.err_pos;
  assign a_st[0]  = b0.tracker_state; assign a_st[1]  = b1.tracker_state;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules in terms of a set of coloured cubes and a
  // count of active blink cycles since completion.
  int           mst [2];   // 0 idle, 1 play, 2 flash, 3 done
  logic [N-1:0] mcol [2];
  int           mfel [2];
  bit           mld [2], merr [2];
  bit           mprev;

  task automatic model_reset();
    mprev = 0;
    for (int m = 0; m < 2; m++) begin
      mst[m] = 0; mcol[m] = '0; mfel[m] = 0; mld[m] = 0; merr[m] = 0;
    end
  endtask

  task automatic model_step();
    bit land;
    land  = dm && !mprev;
    mprev = dm;
    for (int m = 0; m < 2; m++) begin
      mld[m] = 0; merr[m] = 0;
      if (start) begin
        mst[m] = 1; mcol[m] = '0; mfel[m] = 0;
      end else if (mst[m] == 1) begin
        if (land && !pause) begin
          if ($countones(pos) > 1) merr[m] = 1;
          else if (pos != '0) begin
            mcol[m] = (m == 1) ? (mcol[m] ^ pos) : (mcol[m] | pos);
            if ($countones(mcol[m]) == N) begin
              mld[m] = 1; mst[m] = 2; mfel[m] = 0;
            end
          end
        end
      end else if (mst[m] == 2 && !pause) begin
        mfel[m]++;
        if (mfel[m] == 4 * 8) mst[m] = 3;
      end
    end
  endtask

  task automatic check_model();
    logic fl;
    logic [N-1:0] col;
    int cnt;
    for (int m = 0; m < 2; m++) begin
      fl  = (mst[m] == 2) && ((mfel[m] / 4) % 2 == 0);
      col = (mst[m] == 0) ? '0 : (mst[m] == 1) ? mcol[m] : (mst[m] == 2) ? {N{fl}} : ALL;
      cnt = (mst[m] == 0) ? 0 : (mst[m] == 1) ? $countones(mcol[m]) : N;
      check($sformatf("m%0d color", m), 32'(a_col[m]), 32'(col));
      check($sformatf("m%0d cnt", m),   32'(a_cnt[m]), 32'(cnt));
      check($sformatf("m%0d state", m), 32'(a_st[m]),  32'(mst[m]));
      check($sformatf("m%0d flash", m), 32'(a_fl[m]),  32'(fl));
      check($sformatf("m%0d lvl", m),   32'(a_ld[m]),  32'(mld[m]));
      check($sformatf("m%0d err", m),   32'(a_err[m]), 32'(merr[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model();
  endtask

  task automatic land(input logic [N-1:0] p);
    pos = p; dm = 1'b1; tick();
    dm = 1'b0; tick();
  endtask

  typedef struct {
    logic         st, pa, d;
    logic [N-1:0] p;
    logic [N-1:0] c0; int n0;
    logic [N-1:0] c1; int n1;
    logic         err;
  } vec_t;

  vec_t vt [11];
  int   lvl_seen [2];

  initial begin
    model_reset();
    vt[0]  = '{1, 0, 0, 28'h0,       28'h0,  0, 28'h0,  0, 0};
    vt[1]  = '{0, 0, 1, 28'h1,       28'h1,  1, 28'h1,  1, 0};
    vt[2]  = '{0, 0, 0, 28'h0,       28'h1,  1, 28'h1,  1, 0};
    vt[3]  = '{0, 0, 1, 28'h20,      28'h21, 2, 28'h21, 2, 0};
    vt[4]  = '{0, 0, 0, 28'h0,       28'h21, 2, 28'h21, 2, 0};
    vt[5]  = '{0, 0, 1, 28'h20,      28'h21, 2, 28'h1,  1, 0};
    vt[6]  = '{0, 0, 0, 28'h0,       28'h21, 2, 28'h1,  1, 0};
    vt[7]  = '{0, 0, 1, 28'h3,       28'h21, 2, 28'h1,  1, 1};
    vt[8]  = '{0, 0, 0, 28'h0,       28'h21, 2, 28'h1,  1, 0};
    vt[9]  = '{0, 0, 1, 28'h0,       28'h21, 2, 28'h1,  1, 0};
    vt[10] = '{0, 0, 0, 28'h0,       28'h21, 2, 28'h1,  1, 0};

    // Reset state
    repeat (3) tick();
    check("reset state", 32'(a_st[0]), 32'd0);
    check("reset color", 32'(a_col[0]), 32'd0);
    #2 rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      start = vt[i].st; pause = vt[i].pa; dm = vt[i].d; pos = vt[i].p;
      tick();
      check($sformatf("vec%0d col0", i), 32'(a_col[0]), 32'(vt[i].c0));
      check($sformatf("vec%0d cnt0", i), 32'(a_cnt[0]), 32'(vt[i].n0));
      check($sformatf("vec%0d col1", i), 32'(a_col[1]), 32'(vt[i].c1));
      check($sformatf("vec%0d cnt1", i), 32'(a_cnt[1]), 32'(vt[i].n1));
      check($sformatf("vec%0d err", i),  32'(a_err[0]), 32'(vt[i].err));
      check($sformatf("vec%0d state", i), 32'(a_st[0]), 32'd1);
    end
    start = 1'b0;

    // done_move held high: one update only
    pos = 28'h100; dm = 1'b1;
    repeat (10) tick();
    dm = 1'b0; tick();
    check("held col0", 32'(a_col[0]), 32'h121);
    check("held cnt1", 32'(a_cnt[1]), 32'd2);

    // Paused rising edge discarded, not replayed on release
    pause = 1'b1; pos = 28'h200; dm = 1'b1; tick();
    pause = 1'b0; tick(); tick();
    dm = 1'b0; tick();
    check("pause col0", 32'(a_col[0]), 32'h121);

    // Fill the pyramid, blink, settle in DONE
    start = 1'b1; tick(); start = 1'b0;
    lvl_seen[0] = 0; lvl_seen[1] = 0;
    for (int k = 0; k < N; k++) begin
      pos = 28'd1 << k; dm = 1'b1; tick();
      for (int m = 0; m < 2; m++) lvl_seen[m] += int'(a_ld[m]);
      dm = 1'b0; tick();
      for (int m = 0; m < 2; m++) lvl_seen[m] += int'(a_ld[m]);
    end
    check("lvl pulses m0", 32'(lvl_seen[0]), 32'd1);
    check("lvl pulses m1", 32'(lvl_seen[1]), 32'd1);
    repeat (40) tick();
    check("done state", 32'(a_st[0]), 32'd3);
    check("done col",   32'(a_col[0]), 32'(ALL));

    // Reset mid-FLASH
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < N; k++) land(28'd1 << k);
    repeat (5) tick();
    check("pre-reset state", 32'(a_st[0]), 32'd2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("async rst state", 32'(a_st[0]), 32'd0);
    check("async rst col",   32'(a_col[0]), 32'd0);
    check("async rst flash", 32'(a_fl[0]), 32'd0);
    tick();
    #2 rst_n = 1'b1;

    // Start beats a coincident landing
    start = 1'b1; tick(); start = 1'b0;
    land(28'h1);
    start = 1'b1; dm = 1'b1; pos = 28'h2; tick();
    start = 1'b0; tick();
    check("start vs land col", 32'(a_col[0]), 32'd0);
    check("start vs land cnt", 32'(a_cnt[1]), 32'd0);
    dm = 1'b0; tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      start = ($urandom_range(0, 599) == 0);
      pause = ($urandom_range(0, 7) == 0);
      dm    = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 9);
      if (r == 0)      pos = '0;
      else if (r == 1) pos = (28'd1 << $urandom_range(0, 13)) | (28'd1 << $urandom_range(14, 27));
      else             pos = 28'd1 << $urandom_range(0, 27);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qbert_color_tracker.md
Name: qbert_color_tracker

Overview:
- Drives the other end of the cube-colour interface. The map/colour renderer consumes `e_color_state` and produces `position_qb` (one-hot cube under Q*bert) and `done_move` (landing indication). This block consumes those signals and produces `e_color_state`.
- On each valid landing it records which top faces Q*bert has coloured, counts them and detects level completion.
- At completion it runs a blink sequence on the pyramid colours, then holds.
- Sits between the Q*bert layer and the map colour block; it replaces the software colour bookkeeping.

Parameters:
- N_CUBE, 28, number of cubes in the pyramid (width of `position_qb` and `e_color_state`).
- TOGGLE_MODE, 0, 0: landing sets the top colour permanently; 1: landing toggles the top colour.
- FLASH_HALF, 33000000/8, clock cycles per blink half-period.
- FLASH_TOGGLES, 8, number of blink half-periods before entering DONE.

Ports:
- CLK_33  in  1  system clock (33 MHz pixel clock domain).
- reset  in  1  asynchronous, active-low reset.
- e_start_qb  in  1  level start/restart request; high for one or more cycles.
- e_pause_qb  in  1  pause level; landings are ignored while high.
- done_move  in  1  landing indication from the Q*bert layer (level; its rising edge marks a landing).
- position_qb  in  N_CUBE  one-hot cube occupancy; all-zero means off the pyramid.
- e_color_state  out  N_CUBE  top-face colour per cube (1 = target colour) to the map colour block.
- cubes_done  out  5  number of cubes currently at the target colour.
- level_done  out  1  one-cycle pulse when the last cube becomes coloured.
- flash  out  1  blink phase, high during the lit halves of FLASH.
- tracker_state  out  2  0 IDLE, 1 PLAY, 2 FLASH, 3 DONE.
- err_pos  out  1  one-cycle pulse when a landing samples a `position_qb` value that is not one-hot.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - state = IDLE.
  - `e_color_state`, `cubes_done`, `level_done`, `flash`, `err_pos` and the flash counters = 0.
  - Edge register `done_d` = 0.
- Landing detection:
  - `done_d` <= `done_move` on every clock in every state.
  - A landing is `done_move` & ~`done_d`.
  - `position_qb` is sampled in the same cycle as the landing.
- State IDLE:
  - Outputs hold 0.
  - `e_start_qb` = 1 → PLAY with `e_color_state` = 0 and `cubes_done` = 0.
- State PLAY, on a landing while `e_pause_qb` = 0:
  - `position_qb` is all-zero: no update, no `err_pos` (falling off the pyramid is handled elsewhere).
  - `position_qb` has more than one bit set: no update; `err_pos` pulses for 1 cycle.
  - `position_qb` is one-hot, index k, TOGGLE_MODE = 0: if bit k = 0, set it and increment `cubes_done`; otherwise no change.
  - `position_qb` is one-hot, index k, TOGGLE_MODE = 1: invert bit k; `cubes_done` +1 if the bit was 0, −1 if it was 1.
  - Updates are visible on `e_color_state` and `cubes_done` 1 cycle after the landing cycle.
- Completion:
  - Triggered when the update makes `cubes_done` = N_CUBE.
  - `level_done` = 1 in the same cycle the last bit appears.
  - Next state FLASH; flash counter and toggle counter cleared; `flash` = 1.
- Pause:
  - Landings while `e_pause_qb` = 1 are discarded, not deferred.
  - A landing that occurs after pause releases is accepted only if `done_move` makes a fresh rising edge.
- State FLASH:
  - Cycle counter counts 0..FLASH_HALF−1; on wrap, `flash` inverts and the toggle counter increments.
  - `e_color_state` = {N_CUBE{`flash`}}.
  - Landings are ignored.
  - `e_pause_qb` = 1 freezes both counters.
  - After FLASH_TOGGLES wraps → DONE.
- State DONE:
  - `e_color_state` = all ones, `flash` = 0, `cubes_done` = N_CUBE.
  - Waits for `e_start_qb`.
- Restart:
  - `e_start_qb` = 1 in any state → PLAY with `e_color_state` = 0, `cubes_done` = 0, flash counters cleared.
  - Start wins over a simultaneous landing; that landing is dropped.
- Reset mid-operation: asynchronous return to the IDLE reset values, in any state including FLASH.
- Arithmetic:
  - `cubes_done` is unsigned, 5 bits, and never wraps.
  - The decrement is only possible from a set bit, so it never goes below 0.
  - The increment is only possible from a clear bit, so it never exceeds N_CUBE.
- Latency: landing to updated `e_color_state`: 1 clock.

Test Plan:
1. Reset low for 3 cycles, release, pulse `e_start_qb` → `tracker_state` = 1 and `e_color_state` = 0. Then `done_move` rising with `position_qb` = 28'h0000001 → next cycle `e_color_state` = 28'h0000001, `cubes_done` = 1.
2. TOGGLE_MODE = 0: two landings on bit 5 → `e_color_state` = 28'h0000020, `cubes_done` = 1. Repeat with TOGGLE_MODE = 1 → `e_color_state` = 0, `cubes_done` = 0.
3. `position_qb` = 28'h0000003 on a landing → `err_pos` pulses for 1 cycle; state unchanged. `position_qb` = 0 on a landing → no change, no `err_pos`.
4. `done_move` held high for 10 cycles → exactly one update. `e_pause_qb` = 1 during a rising edge → no update.
5. Land on all 28 cubes (FLASH_HALF = 4 for simulation):
   - 28th landing → `level_done` pulses once; `tracker_state` = 2.
   - `flash` toggles every 4 cycles; `e_color_state` alternates 28'hFFFFFFF / 0.
   - After 8 toggles → `tracker_state` = 3 with `e_color_state` = 28'hFFFFFFF.
6. `reset` asserted mid-FLASH → immediately all outputs 0, IDLE. Separately, in PLAY, `e_start_qb` coincident with a landing → `e_color_state` = 0 and the landing is dropped.
